// File: rtl/palette_bank_pkg.sv
// Shared definitions for the double-buffered palette bank.
// Contents: FSM state encoding, colour channel count, and an address-width helper.
// The colour-word width defaults to `RGB_BIT. It falls back to 12 when that macro is not
// supplied by the build.

`ifndef RGB_BIT
`define RGB_BIT 12
`endif

package palette_bank_pkg;

    // Bank-swap controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SYNC = 2'd2
    } pal_state_e;

    // A colour word is split into three equal-width channels
    localparam int unsigned NUM_CH = 3;

    // Address bits needed to index `depth` entries (minimum 1)
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth < 2) ? 32'd1 : 32'($clog2(depth));
    endfunction

endpackage

// File: rtl/palette_fade_stage.sv
// Output register stage of the palette lookup pipeline.
// It subtracts fade_i from each of the three colour channels and clamps each channel at zero.
// The colour and transparency outputs hold when no valid request arrives.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   vld_i/rgb_i/transp_i  incoming lookup result
//   fade_i             per-channel subtrahend (tie to 0 for a plain register)
//   vld_o/rgb_o/transp_o  registered result

module palette_fade_stage
    import palette_bank_pkg::*;
#(
    parameter int unsigned RGB_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld_i,
    input  logic [RGB_W-1:0]        rgb_i,
    input  logic                    transp_i,
    input  logic [RGB_W/NUM_CH-1:0] fade_i,
    output logic                    vld_o,
    output logic [RGB_W-1:0]        rgb_o,
    output logic                    transp_o
);

    localparam int unsigned CW = RGB_W / NUM_CH;

    logic [RGB_W-1:0] sub_c;
    logic             vld_q;
    logic [RGB_W-1:0] rgb_q;
    logic             transp_q;

    // Saturating per-channel subtract
    always_comb begin
        sub_c = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            sub_c[c*CW +: CW] = (rgb_i[c*CW +: CW] > fade_i) ? (rgb_i[c*CW +: CW] - fade_i) : '0;
        end
    end

    // Result register; colour and transparency hold while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= 1'b0;
            rgb_q    <= '0;
            transp_q <= 1'b0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                rgb_q    <= sub_c;
                transp_q <= transp_i;
            end
        end
    end

    assign vld_o    = vld_q;
    assign rgb_o    = rgb_q;
    assign transp_o = transp_q;

endmodule

// File: rtl/palette_bank.sv
// Double-buffered colour palette with a frame-synchronous bank swap.
// The CPU writes into the SHADOW bank, and pixel lookups read the ACTIVE bank.
// A commit arms a swap, and the next vsync performs it.
// After the swap, the new ACTIVE bank is copied into the new SHADOW bank, one entry per cycle.
// Entries that the CPU writes during that copy are kept and not overwritten.
// Optional feature: define PALETTE_FADE_EN to add the fade_lvl port and a second pipeline stage.
// That stage fades each channel. The lookup latency then becomes 2 cycles instead of 1.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cpu_we/cpu_addr/cpu_wdata        shadow-bank write; cpu_rdata = registered shadow readback
//   commit, vsync, busy              swap request, frame pulse, copy in progress
//   pix_vld_i/pix_pal/pix_idx        lookup request
//   pix_vld_o/pix_rgb/pix_transp     lookup result
//   fade_lvl                         per-channel fade amount (PALETTE_FADE_EN only)

module palette_bank
    import palette_bank_pkg::*;
#(
    parameter int unsigned NUM_PAL = 8,
    parameter int unsigned COLORS  = 4,
    parameter int unsigned RGB_W   = `RGB_BIT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cpu_we,
    input  logic [addr_w(NUM_PAL*COLORS)-1:0]    cpu_addr,
    input  logic [RGB_W-1:0]                     cpu_wdata,
    output logic [RGB_W-1:0]                     cpu_rdata,
    input  logic                                 commit,
    input  logic                                 vsync,
    output logic                                 busy,
`ifdef PALETTE_FADE_EN
    input  logic [RGB_W/NUM_CH-1:0]              fade_lvl,
`endif
    input  logic                                 pix_vld_i,
    input  logic [addr_w(NUM_PAL)-1:0]           pix_pal,
    input  logic [addr_w(COLORS)-1:0]            pix_idx,
    output logic                                 pix_vld_o,
    output logic [RGB_W-1:0]                     pix_rgb,
    output logic                                 pix_transp
);

    localparam int unsigned N  = NUM_PAL * COLORS;
    localparam int unsigned AW = addr_w(N);
    localparam int unsigned FW = RGB_W / NUM_CH;

    logic [RGB_W-1:0] mem_q [2][N];

    pal_state_e    state_q;
    logic          act_sel_q;
    logic          pend_q;
    logic [N-1:0]  dirty_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;
    logic [RGB_W-1:0] rdata_q;

    logic          sh_sel;
    logic          copy_en;
    logic [AW-1:0] pix_addr;
    logic [RGB_W-1:0] lk_rgb;
    logic          lk_transp;

    assign sh_sel = ~act_sel_q;

    // The copy skips dirty entries and any entry the CPU writes in this same cycle.
    // Reset gates it off immediately.
    assign copy_en = (state_q == ST_SYNC) && !rst && !dirty_q[cnt_q]
                     && !(cpu_we && (cpu_addr == cnt_q));

    // Bank storage; contents are not reset
    always_ff @(posedge clk) begin
        if (copy_en) begin
            mem_q[sh_sel][cnt_q] <= mem_q[act_sel_q][cnt_q];
        end
        if (cpu_we) begin
            mem_q[sh_sel][cpu_addr] <= cpu_wdata;
        end
    end

    // Swap controller: IDLE -> PEND on commit, PEND -> SYNC on vsync, SYNC copies N entries
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            act_sel_q <= 1'b0;
            pend_q    <= 1'b0;
            dirty_q   <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            if (cpu_we && (state_q == ST_SYNC)) begin
                dirty_q[cpu_addr] <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (commit) begin
                        state_q <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (vsync) begin
                        act_sel_q <= ~act_sel_q;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (commit) begin
                        pend_q <= 1'b1;
                    end
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(N - 1)) begin
                        // Dirty clear overrides any set issued in this last cycle
                        dirty_q <= '0;
                        busy_q  <= 1'b0;
                        pend_q  <= 1'b0;
                        state_q <= (pend_q || commit) ? ST_PEND : ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Shadow readback; old data is returned on a same-address write
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[sh_sel][cpu_addr];
        end
    end

    assign cpu_rdata = rdata_q;
    assign busy      = busy_q;

    // Combinational ACTIVE-bank lookup; the old bank is still selected in the vsync cycle
    assign pix_addr  = {pix_pal, pix_idx};
    assign lk_rgb    = mem_q[act_sel_q][pix_addr];
    assign lk_transp = (pix_idx == '0);

    logic             st_vld;
    logic [RGB_W-1:0] st_rgb;
    logic             st_transp;
    logic [FW-1:0]    st_fade;

`ifdef PALETTE_FADE_EN
    logic             s1_vld_q;
    logic [RGB_W-1:0] s1_rgb_q;
    logic             s1_transp_q;

    // First lookup stage; the fade stage behind it adds the second cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_rgb_q    <= '0;
            s1_transp_q <= 1'b0;
        end else begin
            s1_vld_q <= pix_vld_i;
            if (pix_vld_i) begin
                s1_rgb_q    <= lk_rgb;
                s1_transp_q <= lk_transp;
            end
        end
    end

    assign st_vld    = s1_vld_q;
    assign st_rgb    = s1_rgb_q;
    assign st_transp = s1_transp_q;
    assign st_fade   = fade_lvl;
`else
    // With no fade, the stage is just the single output register
    assign st_vld    = pix_vld_i;
    assign st_rgb    = lk_rgb;
    assign st_transp = lk_transp;
    assign st_fade   = '0;
`endif

    palette_fade_stage #(
        .RGB_W (RGB_W)
    ) u_fade (
        .clk      (clk),
        .rst      (rst),
        .vld_i    (st_vld),
        .rgb_i    (st_rgb),
        .transp_i (st_transp),
        .fade_i   (st_fade),
        .vld_o    (pix_vld_o),
        .rgb_o    (pix_rgb),
        .transp_o (pix_transp)
    );

endmodule

// File: tb/tb_palette_bank.sv
// Self-checking bench for palette_bank.
// It runs directed scenarios and then random traffic.
// A per-cycle array model of both banks supplies every expected value.

module tb_palette_bank;

    localparam int unsigned NUM_PAL = 8;
    localparam int unsigned COLORS  = 4;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned N       = NUM_PAL * COLORS;
`ifdef PALETTE_FADE_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_we;
    logic [4:0]  cpu_addr;
    logic [11:0] cpu_wdata;
    logic [11:0] cpu_rdata;
    logic        commit;
    logic        vsync;
    logic        busy;
    logic        pix_vld_i;
    logic [2:0]  pix_pal;
    logic [1:0]  pix_idx;
    logic        pix_vld_o;
    logic [11:0] pix_rgb;
    logic        pix_transp;
`ifdef PALETTE_FADE_EN
    logic [3:0]  fade_lvl;
`endif

    always #5 clk = ~clk;

    palette_bank #(
        .NUM_PAL (NUM_PAL),
        .COLORS  (COLORS),
        .RGB_W   (RGB_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .commit     (commit),
        .vsync      (vsync),
        .busy       (busy),
`ifdef PALETTE_FADE_EN
        .fade_lvl   (fade_lvl),
`endif
        .pix_vld_i  (pix_vld_i),
        .pix_pal    (pix_pal),
        .pix_idx    (pix_idx),
        .pix_vld_o  (pix_vld_o),
        .pix_rgb    (pix_rgb),
        .pix_transp (pix_transp)
    );

    // Reference model: bank contents with known flags, plus swap bookkeeping
    logic [11:0] m_bank [2][N];
    bit          m_kn   [2][N];
    bit          m_cw   [N];
    int          m_act;
    int          m_sync_left;
    bit          m_pend;
    bit          m_latch;

    bit          e_vld, e_tr, e_busy, e_rgb_kn, e_rd_kn;
    logic [11:0] e_rgb, e_rd;
`ifdef PALETTE_FADE_EN
    bit          s1_vld, s1_tr, s1_kn;
    logic [11:0] s1_rgb;
`endif

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

`ifdef PALETTE_FADE_EN
    function automatic logic [11:0] fade_fn(input logic [11:0] rgb, input logic [3:0] f);
        logic [11:0] r;
        int d;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            d = int'(rgb[i*4 +: 4]) - int'(f);
            if (d < 0) d = 0;
            r[i*4 +: 4] = 4'(d);
        end
        return r;
    endfunction
`endif

    task automatic shadow_write(input int a);
        m_bank[1-m_act][a] = cpu_wdata;
        m_kn[1-m_act][a]   = 1'b1;
    endtask

    // Advance one clock. The model predicts the post-edge outputs, then the DUT outputs are compared.
    task automatic tick();
        int a_pix;
        int a_cpu;
        int k;
        a_pix = int'(pix_pal) * int'(COLORS) + int'(pix_idx);
        a_cpu = int'(cpu_addr);
        if (rst) begin
            m_act = 0; m_sync_left = 0; m_pend = 0; m_latch = 0;
            foreach (m_cw[i]) m_cw[i] = 1'b0;
            e_vld = 0; e_rgb = '0; e_tr = 0; e_rgb_kn = 1; e_rd = '0; e_rd_kn = 1; e_busy = 0;
`ifdef PALETTE_FADE_EN
            s1_vld = 0; s1_rgb = '0; s1_tr = 0; s1_kn = 1;
`endif
        end else begin
`ifdef PALETTE_FADE_EN
            e_vld = s1_vld;
            if (s1_vld) begin
                e_rgb = fade_fn(s1_rgb, fade_lvl); e_tr = s1_tr; e_rgb_kn = s1_kn;
            end
            s1_vld = pix_vld_i;
            if (pix_vld_i) begin
                s1_rgb = m_bank[m_act][a_pix]; s1_tr = (pix_idx == 2'd0); s1_kn = m_kn[m_act][a_pix];
            end
`else
            e_vld = pix_vld_i;
            if (pix_vld_i) begin
                e_rgb = m_bank[m_act][a_pix]; e_tr = (pix_idx == 2'd0); e_rgb_kn = m_kn[m_act][a_pix];
            end
`endif
            e_rd    = m_bank[1-m_act][a_cpu];
            e_rd_kn = m_kn[1-m_act][a_cpu];
            if (m_sync_left > 0) begin
                k = int'(N) - m_sync_left;
                if (cpu_we) m_cw[a_cpu] = 1'b1;
                if (!m_cw[k]) begin
                    m_bank[1-m_act][k] = m_bank[m_act][k];
                    m_kn[1-m_act][k]   = m_kn[m_act][k];
                end
                if (cpu_we) shadow_write(a_cpu);
                if (commit) m_latch = 1'b1;
                m_sync_left--;
                if (m_sync_left == 0) begin
                    m_pend = m_latch; m_latch = 1'b0;
                    foreach (m_cw[i]) m_cw[i] = 1'b0;
                end
            end else begin
                if (cpu_we) shadow_write(a_cpu);
                if (m_pend) begin
                    if (vsync) begin
                        m_act = 1 - m_act; m_sync_left = int'(N); m_pend = 1'b0;
                    end
                end else if (commit) begin
                    m_pend = 1'b1;
                end
            end
            e_busy = (m_sync_left > 0);
        end
        @(posedge clk);
        #1;
        chk("pix_vld_o", 32'(pix_vld_o), 32'(e_vld));
        if (e_rgb_kn) chk("pix_rgb", 32'(pix_rgb), 32'(e_rgb));
        chk("pix_transp", 32'(pix_transp), 32'(e_tr));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_rd_kn) chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rd));
    endtask

    task automatic wr(input int a, input logic [11:0] d);
        cpu_we = 1'b1; cpu_addr = 5'(a); cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1; tick(); commit = 1'b0;
    endtask

    task automatic do_vsync();
        vsync = 1'b1; tick(); vsync = 1'b0;
    endtask

    task automatic wait_sync();
        for (int i = 0; i < 2 * int'(N) && m_sync_left > 0; i++) tick();
    endtask

    task automatic look(input int pal, input int idx, input logic [11:0] exp, input string tag);
        pix_vld_i = 1'b1; pix_pal = 3'(pal); pix_idx = 2'(idx);
        tick();
        pix_vld_i = 1'b0;
        for (int i = 1; i < int'(LAT); i++) tick();
        chk(tag, 32'(pix_rgb), 32'(exp));
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        m_act = 0; m_sync_left = 0; m_pend = 0; m_latch = 0;
        rst = 1'b1; cpu_we = 1'b0; commit = 1'b0; vsync = 1'b0; pix_vld_i = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; pix_pal = '0; pix_idx = '0;
`ifdef PALETTE_FADE_EN
        fade_lvl = '0;
`endif
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_rgb", 32'(pix_rgb), 32'd0);
        rst = 1'b0;

        // Fill the shadow bank and swap so that both banks hold defined data
        for (int a = 0; a < int'(N); a++) wr(a, 12'($urandom));
        do_commit(); do_vsync(); wait_sync();

        // Commit then vsync makes the new entry visible
        wr(5, 12'hF00); do_commit(); do_vsync(); wait_sync();
        look(1, 1, 12'hF00, "swap_rgb");
        chk("swap_transp", 32'(pix_transp), 32'd0);

        // Write without commit: vsync changes nothing
        wr(5, 12'h0F0); do_vsync();
        look(1, 1, 12'hF00, "no_commit_rgb");

        // Commit and vsync together only arm the swap
        commit = 1'b1; vsync = 1'b1; tick(); commit = 1'b0; vsync = 1'b0;
        chk("same_cycle_busy", 32'(busy), 32'd0);
        look(1, 1, 12'hF00, "same_cycle_noswap");
        vsync = 1'b1; tick(); vsync = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        wait_sync();
        look(1, 1, 12'h0F0, "late_swap_rgb");

        // A CPU write during the copy survives it
        do_commit(); do_vsync(); tick();
        wr(31, 12'hABC); wait_sync();
        cpu_addr = 5'd31; tick();
        chk("dirty_keep", 32'(cpu_rdata), 32'hABC);

        // Reset in the third copy cycle aborts the copy and returns to bank 0
        wr(20, 12'h123); do_commit(); do_vsync(); tick(); tick();
        rst = 1'b1; pix_vld_i = 1'b1; tick(); rst = 1'b0; pix_vld_i = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vld", 32'(pix_vld_o), 32'd0);
        look(5, 0, m_bank[0][20], "act_sel_reset");

`ifdef PALETTE_FADE_EN
        wr(7, 12'h888); do_commit(); do_vsync(); wait_sync();
        fade_lvl = 4'hA; look(1, 3, 12'h000, "fade_sat");
        fade_lvl = 4'h3; look(1, 3, 12'h555, "fade_sub");
        fade_lvl = 4'h0;
`endif

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cpu_we    = !rst && ($urandom_range(0, 3) == 0);
            cpu_addr  = 5'($urandom);
            cpu_wdata = 12'($urandom);
            commit    = ($urandom_range(0, 15) == 0);
            vsync     = ($urandom_range(0, 19) == 0);
            pix_vld_i = 1'($urandom);
            pix_pal   = 3'($urandom);
            pix_idx   = 2'($urandom);
`ifdef PALETTE_FADE_EN
            fade_lvl  = 4'($urandom);
`endif
            tick();
        end
        rst = 1'b0; cpu_we = 1'b0; commit = 1'b0; vsync = 1'b0; pix_vld_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
